// File: rtl/clock_time_ctrl.sv
// Purpose: HH:MM:SS sequencer (1 s prescaler, wrap decode, time-set FSM, blink strobe) for three external BCD counters.
// Latency: strobes are registered and appear 1 clk after a tick; button strobes appear 3 clk after the raw input rises.
// Backpressure: none; the counters must accept every one-cycle en/clr strobe.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   btn_mode, btn_inc            raw pre-debounced push-buttons (async to clk)
//   sec_bcd, min_bcd, hr_bcd     current {tens,ones} values of the counters
//   sec_en/min_en/hr_en          one-cycle increment strobes
//   sec_clr/min_clr/hr_clr       one-cycle synchronous clear strobes
//   mode                         00=RUN, 01=SET_HH, 10=SET_MM
//   blink                        blank strobe for the field being set, 0 in RUN
//
// Optional feature macro: CLOCK_TIME_CTRL_AUTOREPEAT_EN (auto-repeat of btn_inc while held in a set mode).
module clock_time_ctrl #(
    parameter int CLK_DIV    = 50000000,
    parameter int BLINK_DIV  = 12500000,
    parameter int REPEAT_DIV = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [7:0] sec_bcd,
    input  logic [7:0] min_bcd,
    input  logic [7:0] hr_bcd,
    output logic       sec_en,
    output logic       min_en,
    output logic       hr_en,
    output logic       sec_clr,
    output logic       min_clr,
    output logic       hr_clr,
    output logic [1:0] mode,
    output logic       blink
);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        SET_HH = 2'b01,
        SET_MM = 2'b10
    } state_t;

    localparam int PS_W = $clog2(CLK_DIV + 1);
    localparam int BL_W = $clog2(BLINK_DIV + 1);
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLK_DIV - 1);
    localparam logic [BL_W-1:0] BL_MAX = BL_W'(BLINK_DIV - 1);

    state_t          state;
    logic            start_pend;
    logic            mode_s1, mode_s2, mode_d;
    logic            inc_s1, inc_s2, inc_d;
    logic            mode_evt, inc_raw, inc_evt;
    logic [PS_W-1:0] ps_cnt;
    logic [BL_W-1:0] bl_cnt;
    logic            tick;
    logic            sec_top, sec_bad, min_top, min_bad, hr_wrap;

    // Two-flop synchronizers followed by a rising-edge detector per button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_s1 <= 1'b0;
            mode_s2 <= 1'b0;
            mode_d  <= 1'b0;
            inc_s1  <= 1'b0;
            inc_s2  <= 1'b0;
            inc_d   <= 1'b0;
        end else begin
            mode_s1 <= btn_mode;
            mode_s2 <= mode_s1;
            mode_d  <= mode_s2;
            inc_s1  <= btn_inc;
            inc_s2  <= inc_s1;
            inc_d   <= inc_s2;
        end
    end

    assign mode_evt = mode_s2 & ~mode_d;
    assign inc_raw  = inc_s2 & ~inc_d;

`ifdef CLOCK_TIME_CTRL_AUTOREPEAT_EN
    // Hold counter restarts at each fresh press; the first repeat fires
    // 4*REPEAT_DIV clk after the press, then it reloads so that later
    // repeats are REPEAT_DIV apart.
    localparam int RP_W = $clog2(4 * REPEAT_DIV + 1);
    localparam logic [RP_W-1:0] RP_FIRE   = RP_W'(4 * REPEAT_DIV - 1);
    localparam logic [RP_W-1:0] RP_RELOAD = RP_W'(3 * REPEAT_DIV);

    logic [RP_W-1:0] rp_cnt;
    logic            rep_evt;

    assign rep_evt = (state != RUN) && inc_s2 && !inc_raw && (rp_cnt == RP_FIRE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp_cnt <= '0;
        end else if ((state == RUN) || !inc_s2 || mode_evt || inc_raw) begin
            rp_cnt <= '0;
        end else if (rp_cnt == RP_FIRE) begin
            rp_cnt <= RP_RELOAD;
        end else begin
            rp_cnt <= rp_cnt + 1'b1;
        end
    end

    assign inc_evt = inc_raw | rep_evt;
`else
    assign inc_evt = inc_raw;
`endif

    // Prescaler runs only in RUN; any non-RUN cycle or a mode change holds
    // it at 0 so the first tick after returning to RUN is CLK_DIV clk later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt <= '0;
        end else if ((state != RUN) || mode_evt || (ps_cnt == PS_MAX)) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + 1'b1;
        end
    end

    assign tick = (state == RUN) && (ps_cnt == PS_MAX);

    // Full 8-bit decode: exact terminal values carry, anything outside the
    // legal range is cleared (no carry) so a glitched counter self-repairs.
    assign sec_top = (sec_bcd == 8'h59);
    assign sec_bad = (sec_bcd[3:0] > 4'd9) || (sec_bcd > 8'h59);
    assign min_top = (min_bcd == 8'h59);
    assign min_bad = (min_bcd[3:0] > 4'd9) || (min_bcd > 8'h59);
    assign hr_wrap = (hr_bcd[3:0] > 4'd9) || (hr_bcd >= 8'h23);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            start_pend <= 1'b1;
            sec_en     <= 1'b0;
            min_en     <= 1'b0;
            hr_en      <= 1'b0;
            sec_clr    <= 1'b0;
            min_clr    <= 1'b0;
            hr_clr     <= 1'b0;
        end else begin
            sec_en  <= 1'b0;
            min_en  <= 1'b0;
            hr_en   <= 1'b0;
            sec_clr <= 1'b0;
            min_clr <= 1'b0;
            hr_clr  <= 1'b0;
            if (start_pend) begin
                // First clk after reset release zeroes the whole chain.
                start_pend <= 1'b0;
                sec_clr    <= 1'b1;
                min_clr    <= 1'b1;
                hr_clr     <= 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        if (mode_evt) begin
                            state   <= SET_HH;
                            sec_clr <= 1'b1;
                        end else if (tick) begin
                            if (sec_top) begin
                                sec_clr <= 1'b1;
                                if (min_top) begin
                                    min_clr <= 1'b1;
                                    if (hr_wrap) hr_clr <= 1'b1;
                                    else         hr_en  <= 1'b1;
                                end else if (min_bad) begin
                                    min_clr <= 1'b1;
                                end else begin
                                    min_en <= 1'b1;
                                end
                            end else if (sec_bad) begin
                                sec_clr <= 1'b1;
                            end else begin
                                sec_en <= 1'b1;
                            end
                        end
                    end
                    SET_HH: begin
                        if (mode_evt) begin
                            state <= SET_MM;
                        end else if (inc_evt) begin
                            if (hr_wrap) hr_clr <= 1'b1;
                            else         hr_en  <= 1'b1;
                        end
                    end
                    SET_MM: begin
                        if (mode_evt) begin
                            state <= RUN;
                        end else if (inc_evt) begin
                            if (min_top || min_bad) min_clr <= 1'b1;
                            else                    min_en  <= 1'b1;
                        end
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end

    assign mode = state;

    // Blink phase restarts from 0 on every entry into a set mode and is
    // already low in the first RUN cycle after leaving SET_MM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bl_cnt <= '0;
            blink  <= 1'b0;
        end else if ((state == RUN) || ((state == SET_MM) && mode_evt)) begin
            bl_cnt <= '0;
            blink  <= 1'b0;
        end else if (bl_cnt == BL_MAX) begin
            bl_cnt <= '0;
            blink  <= ~blink;
        end else begin
            bl_cnt <= bl_cnt + 1'b1;
        end
    end

endmodule

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
- Sequencer for the HH:MM:SS chain built from three 00-99 BCD counter instances (seconds, minutes, hours).
- Generates the 1 Hz tick and decodes the current counter values.
- Drives per-counter enable and clear strobes so seconds and minutes wrap at 59 and hours at 23.
- Owns the time-set FSM (RUN -> SET_HH -> SET_MM) driven by two push-buttons, plus a blink strobe for the display mux.

Parameters:
- CLK_DIV, 50000000, clk cycles per 1 s tick; minimum 8.
- BLINK_DIV, 12500000, clk cycles per blink toggle; 2 Hz blink at the default.
- REPEAT_DIV, 10000000, cycles between auto-repeat increments; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_mode  in  1  raw mode button, active high, asynchronous to clk
- btn_inc  in  1  raw increment button, active high, asynchronous to clk
- sec_bcd  in  8  {tens,ones} from the seconds counter
- min_bcd  in  8  {tens,ones} from the minutes counter
- hr_bcd  in  8  {tens,ones} from the hours counter
- sec_en, min_en, hr_en  out  1 each  one-cycle enable pulse to the matching counter
- sec_clr, min_clr, hr_clr  out  1 each  one-cycle synchronous clear to the matching counter's active-high rst
- mode  out  2  00=RUN, 01=SET_HH, 10=SET_MM
- blink  out  1  display blank strobe for the field being set; 0 in RUN

Behaviour:
- Reset (rst_n low, asynchronous):
  - all en/clr outputs 0, blink 0, mode RUN.
  - prescaler, blink and repeat counters 0; synchronizer and edge flops 0.
  - sec_clr/min_clr/hr_clr also pulse high for the first clk after reset release, so the chain starts at 00:00:00.
- Button conditioning:
  - each button passes through a 2-flop synchronizer, then a rising-edge detector.
  - one press gives one event, 3 clk after the input rises.
  - no debounce inside this block; buttons arrive pre-debounced.
- Prescaler:
  - counts 0..CLK_DIV-1; tick is high for one clk at terminal count.
  - runs only in RUN; cleared on entry to SET_HH.
- Strobes:
  - all strobes are registered, asserted the clk after the qualifying event, exactly one cycle wide.
  - counter values update one clk after the strobe.
- RUN, on tick:
  - sec_bcd != 0x59 -> sec_en.
  - sec_bcd == 0x59 -> sec_clr, plus:
    - min_bcd != 0x59 -> min_en.
    - min_bcd == 0x59 -> min_clr, plus hr_clr if hr_bcd == 0x23, else hr_en.
  - Consequence: 23:59:59 -> 00:00:00 in one strobe cycle.
- FSM transitions on a mode event: RUN -> SET_HH -> SET_MM -> RUN.
  - Entering SET_HH also pulses sec_clr.
  - Returning to RUN restarts the prescaler from 0, so the first tick lands CLK_DIV cycles later.
- SET_HH, on an inc event: hr_en, or hr_clr if hr_bcd == 0x23. Minutes and seconds are untouched.
- SET_MM, on an inc event: min_en, or min_clr if min_bcd == 0x59. Never carries into hours.
- Simultaneous events:
  - mode and inc in the same cycle: the mode event wins and inc is dropped.
  - no tick is generated outside RUN.
- Decoding:
  - compare the full 8-bit BCD values.
  - a non-BCD or out-of-range input (e.g. hr_bcd 0x24..0x99 after glitch) issues clr on the next increment/tick for that field, self-repairing to 00.
- blink:
  - toggles every BLINK_DIV clk while in SET_HH/SET_MM.
  - forced 0 and its counter cleared in RUN.
- Reset mid-operation: any state returns to RUN at once; pending strobes are dropped.

Optional Feature:
- Macro: CLOCK_TIME_CTRL_AUTOREPEAT_EN.
- Defined:
  - in SET_HH/SET_MM, holding the synchronized btn_inc high beyond 4*REPEAT_DIV clk after the initial event generates further inc events.
  - repeat events are spaced REPEAT_DIV clk apart until release, and follow the same wrap rules.
  - the repeat counter is cleared on release or a mode change.
- Undefined: exactly one inc event per press, and no repeat counter logic is synthesized.

Test Plan (CLK_DIV=8, BLINK_DIV=4, REPEAT_DIV=4 unless noted; bench models three bcd counters):
- Reset release: rst_n low then high -> sec_clr/min_clr/hr_clr high for 1 clk, mode=00, time 00:00:00; after 8 clk, sec_en pulse -> 00:00:01.
- Full rollover: preload 23:59:59, wait one tick -> single cycle with sec_clr=min_clr=hr_clr=1, sec_en=min_en=hr_en=0; time 00:00:00.
- Minute carry: preload 09:59:59, tick -> sec_clr, min_clr, hr_en -> 10:00:00; preload 10:14:59, tick -> sec_clr, min_en -> 10:15:00.
- Set hours: mode press -> mode=01, sec_clr pulse; 3 inc presses from 22 -> hr_en, hr_clr, hr_en -> hours 01; blink toggles every 4 clk; no sec_en while in set mode.
- Set minutes and exit: mode press -> 10; inc from 59 -> min_clr, hours unchanged; mode press -> 00, next sec_en exactly 8 clk later; mode+inc same cycle -> mode advances, no en.
- Autorepeat (macro defined): in SET_MM hold btn_inc 40 clk -> first min_en, then additional min_en every 4 clk after the 16-clk hold threshold; macro undefined -> exactly one min_en.
